// File: rtl/if_pkg.sv
// Shared widths, reset constants and fetch-state encoding for the instruction-fetch stage.
package if_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [1:0] fetch_state_t;

   localparam fetch_state_t FETCH    = 2'd0;
   localparam fetch_state_t BUFFERED = 2'd1;
   localparam fetch_state_t DISCARD  = 2'd2;

endpackage

// File: rtl/if_fetch_buffer.sv
// One-entry fetch buffer: holds an instruction word that arrived while the pipeline was frozen.
module if_fetch_buffer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] instr_in,
   output logic         valid,
   output logic [W-1:0] instr
);

   logic         valid_r;
   logic [W-1:0] instr_r;

   // Buffer entry: clear wins over load, otherwise hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         instr_r <= {W{1'b0}};
      end else if (clear) begin
         valid_r <= 1'b0;
         instr_r <= instr_r;
      end else if (load) begin
         valid_r <= 1'b1;
         instr_r <= instr_in;
      end else begin
         valid_r <= valid_r;
         instr_r <= instr_r;
      end
   end

   assign valid = valid_r;
   assign instr = instr_r;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: PC register, imem request logic and IF/ID register with a one-entry fetch buffer.
// Optional IF_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_fetch_stage #(
   parameter int              XLEN      = if_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = if_pkg::RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            pc_freeze,
   input  logic            IF_ID_freeze,
   input  logic            IF_ID_flush,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] ID_pc,
   output logic [XLEN-1:0] ID_instr,
   output logic            ID_valid,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]     perf_stall_cnt,
   output logic [31:0]     perf_flush_cnt,
`endif
   output logic            fetch_stall
);

   import if_pkg::*;

   localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'd4};

   fetch_state_t    state_r, state_nxt_s;
   logic [XLEN-1:0] pc_r, pc_nxt_s;
   logic [XLEN-1:0] target_r, target_nxt_s;
   logic [XLEN-1:0] id_pc_r, id_pc_nxt_s;
   logic [XLEN-1:0] id_instr_r, id_instr_nxt_s;
   logic            id_valid_r, id_valid_nxt_s;
   logic            buf_valid_s, buf_load_s, buf_clear_s;
   logic [XLEN-1:0] buf_instr_s, word_s;
   logic            freeze_s, fetching_s, avail_s, outstanding_s;

   if_fetch_buffer #(.W(XLEN)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load_s),
      .clear    (buf_clear_s),
      .instr_in (imem_rdata),
      .valid    (buf_valid_s),
      .instr    (buf_instr_s)
   );

   // A lone pc_freeze or IF_ID_freeze freezes both; the buffer only ever holds a word in BUFFERED.
   assign freeze_s      = pc_freeze | IF_ID_freeze;
   assign fetching_s    = (state_r == FETCH);
   assign avail_s       = (fetching_s & imem_ready) | buf_valid_s;
   assign outstanding_s = (state_r != BUFFERED) & ~imem_ready;
   assign word_s        = buf_valid_s ? buf_instr_s : imem_rdata;

   assign imem_req    = ~rst & (state_r != BUFFERED);
   assign imem_addr   = pc_r;
   assign fetch_stall = (state_r == DISCARD) | ~avail_s;

   // Next-state selection in priority order: redirect, discard drain, freeze, normal advance.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      target_nxt_s   = target_r;
      id_pc_nxt_s    = id_pc_r;
      id_instr_nxt_s = id_instr_r;
      id_valid_nxt_s = id_valid_r;
      buf_load_s     = 1'b0;
      buf_clear_s    = 1'b0;
      if (redirect_valid) begin
         id_pc_nxt_s    = {XLEN{1'b0}};
         id_instr_nxt_s = NOP_INSTR;
         id_valid_nxt_s = 1'b0;
         // PC stays on the stale address until the in-flight access completes.
         if (outstanding_s) begin
            target_nxt_s = redirect_pc;
            state_nxt_s  = DISCARD;
         end else begin
            pc_nxt_s    = redirect_pc;
            buf_clear_s = 1'b1;
            state_nxt_s = FETCH;
         end
      end else if (state_r == DISCARD) begin
         id_pc_nxt_s    = {XLEN{1'b0}};
         id_instr_nxt_s = NOP_INSTR;
         id_valid_nxt_s = 1'b0;
         if (imem_ready) begin
            pc_nxt_s    = target_r;
            state_nxt_s = FETCH;
         end else begin
            state_nxt_s = DISCARD;
         end
      end else if (freeze_s) begin
         if (IF_ID_flush) begin
            id_pc_nxt_s    = {XLEN{1'b0}};
            id_instr_nxt_s = NOP_INSTR;
            id_valid_nxt_s = 1'b0;
         end else begin
            id_valid_nxt_s = id_valid_r;
         end
         if (fetching_s && imem_ready) begin
            buf_load_s  = 1'b1;
            state_nxt_s = BUFFERED;
         end else begin
            state_nxt_s = state_r;
         end
      end else if (avail_s) begin
         if (IF_ID_flush) begin
            id_pc_nxt_s    = {XLEN{1'b0}};
            id_instr_nxt_s = NOP_INSTR;
            id_valid_nxt_s = 1'b0;
         end else begin
            id_pc_nxt_s    = pc_r;
            id_instr_nxt_s = word_s;
            id_valid_nxt_s = 1'b1;
         end
         pc_nxt_s    = pc_r + PC_STEP;
         buf_clear_s = 1'b1;
         state_nxt_s = FETCH;
      end else begin
         id_pc_nxt_s    = {XLEN{1'b0}};
         id_instr_nxt_s = NOP_INSTR;
         id_valid_nxt_s = 1'b0;
      end
   end

   // State, PC, redirect target and IF/ID registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= FETCH;
         pc_r       <= RESET_PC;
         target_r   <= RESET_PC;
         id_pc_r    <= {XLEN{1'b0}};
         id_instr_r <= NOP_INSTR;
         id_valid_r <= 1'b0;
      end else begin
         state_r    <= (state_nxt_s == FETCH || state_nxt_s == BUFFERED ||
                        state_nxt_s == DISCARD) ? state_nxt_s : FETCH;
         pc_r       <= pc_nxt_s;
         target_r   <= target_nxt_s;
         id_pc_r    <= id_pc_nxt_s;
         id_instr_r <= id_instr_nxt_s;
         id_valid_r <= id_valid_nxt_s;
      end
   end

   assign ID_pc    = id_pc_r;
   assign ID_instr = id_instr_r;
   assign ID_valid = id_valid_r;

`ifdef IF_PERF_CNT_EN
   logic [31:0] stall_cnt_r, flush_cnt_r;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r <= 32'd0;
         flush_cnt_r <= 32'd0;
      end else begin
         if (fetch_stall && stall_cnt_r != 32'hFFFF_FFFF) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end
         if ((redirect_valid || IF_ID_flush) && flush_cnt_r != 32'hFFFF_FFFF) begin
            flush_cnt_r <= flush_cnt_r + 32'd1;
         end
      end
   end

   assign perf_stall_cnt = stall_cnt_r;
   assign perf_flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scenario bench for if_fetch_stage: expected IF/ID contents are queued when stimulus is
// driven and popped after the clock edge that should produce them.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } id_t;

   logic        clk = 1'b0;
   logic        rst, pc_freeze, IF_ID_freeze, IF_ID_flush, redirect_valid, imem_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, ID_pc, ID_instr;
   logic        imem_req, ID_valid, fetch_stall;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int  total = 0;
   int  bad   = 0;
   id_t exp_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_0000;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   if_fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .pc_freeze      (pc_freeze),
      .IF_ID_freeze   (IF_ID_freeze),
      .IF_ID_flush    (IF_ID_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .ID_pc          (ID_pc),
      .ID_instr       (ID_instr),
      .ID_valid       (ID_valid),
`ifdef IF_PERF_CNT_EN
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt),
`endif
      .fetch_stall    (fetch_stall)
   );

   task automatic drive(input logic r, input logic pf, input logic idf, input logic fl,
                        input logic rv, input logic [31:0] rpc, input logic rdy);
      rst = r; pc_freeze = pf; IF_ID_freeze = idf; IF_ID_flush = fl;
      redirect_valid = rv; redirect_pc = rpc; imem_ready = rdy;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      id_t e;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      total++;
      if (imem_req !== 1'b0) begin
         bad++; $display("FAIL reset_req got=%b want=0", imem_req);
      end
      exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
      tick;
      e = exp_q.pop_front();
      total++;
      if (ID_valid !== e.valid || ID_instr !== e.instr || ID_pc !== e.pc) begin
         bad++; $display("FAIL reset_id got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                         ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
      end
   endtask

   task automatic test_stream;
      id_t e;
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || fetch_stall !== 1'b0) begin
            bad++; $display("FAIL stream_req%0d got req=%b addr=%h stall=%b want 1 %h 0",
                            k, imem_req, imem_addr, fetch_stall, 32'(4 * k));
         end
         exp_q.push_back('{pc: 32'(4 * k), instr: mem_word(32'(4 * k)), valid: 1'b1});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || ID_pc !== e.pc) begin
            bad++; $display("FAIL stream_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_wait;
      id_t e;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, (k == 3));
         total++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h8 || fetch_stall !== (k != 3)) begin
            bad++; $display("FAIL wait_req%0d got req=%b addr=%h stall=%b want 1 00000008 %b",
                            k, imem_req, imem_addr, fetch_stall, (k != 3));
         end
         if (k == 3) exp_q.push_back('{pc: 32'h8, instr: mem_word(32'h8), valid: 1'b1});
         else        exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || (e.valid && ID_pc !== e.pc)) begin
            bad++; $display("FAIL wait_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_freeze;
      id_t  e;
      logic pf[3]   = '{1'b1, 1'b1, 1'b0};
      logic idf[3]  = '{1'b1, 1'b0, 1'b0};
      logic rdy[3]  = '{1'b1, 1'b0, 1'b0};
      logic wreq[3] = '{1'b1, 1'b0, 1'b0};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, pf[k], idf[k], 1'b0, 1'b0, 32'h0, rdy[k]);
         total++;
         if (imem_req !== wreq[k] || imem_addr !== 32'hC) begin
            bad++; $display("FAIL freeze_req%0d got req=%b addr=%h want %b 0000000c",
                            k, imem_req, imem_addr, wreq[k]);
         end
         if (k == 2) exp_q.push_back('{pc: 32'hC, instr: mem_word(32'hC), valid: 1'b1});
         else        exp_q.push_back('{pc: 32'h8, instr: mem_word(32'h8), valid: 1'b1});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || ID_pc !== e.pc) begin
            bad++; $display("FAIL freeze_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_redirect_discard;
      id_t         e;
      logic        rv[5]    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic        rdy[5]   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] waddr[5] = '{32'h10, 32'h10, 32'h10, 32'h100, 32'h100};
      for (int k = 0; k < 5; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, rv[k], 32'h100, rdy[k]);
         total++;
         if (imem_req !== 1'b1 || imem_addr !== waddr[k] || (k < 3 && fetch_stall !== 1'b1)) begin
            bad++; $display("FAIL discard_req%0d got req=%b addr=%h stall=%b want 1 %h",
                            k, imem_req, imem_addr, fetch_stall, waddr[k]);
         end
         if (k == 4) exp_q.push_back('{pc: 32'h100, instr: mem_word(32'h100), valid: 1'b1});
         else        exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || (e.valid && ID_pc !== e.pc)) begin
            bad++; $display("FAIL discard_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_redirect_freeze;
      id_t         e;
      logic [31:0] waddr[3] = '{32'h104, 32'h200, 32'h200};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, (k == 0), (k == 0), 1'b0, (k == 0), 32'h200, (k != 1));
         total++;
         if (imem_addr !== waddr[k]) begin
            bad++; $display("FAIL rfrz_addr%0d got=%h want=%h", k, imem_addr, waddr[k]);
         end
         if (k == 2) exp_q.push_back('{pc: 32'h200, instr: mem_word(32'h200), valid: 1'b1});
         else        exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || (e.valid && ID_pc !== e.pc)) begin
            bad++; $display("FAIL rfrz_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_flush;
      id_t         e;
      logic [31:0] waddr[2] = '{32'h204, 32'h208};
      for (int k = 0; k < 2; k++) begin
         drive(1'b0, 1'b0, 1'b0, (k == 0), 1'b0, 32'h0, 1'b1);
         total++;
         if (imem_addr !== waddr[k]) begin
            bad++; $display("FAIL flush_addr%0d got=%h want=%h", k, imem_addr, waddr[k]);
         end
         if (k == 1) exp_q.push_back('{pc: 32'h208, instr: mem_word(32'h208), valid: 1'b1});
         else        exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || (e.valid && ID_pc !== e.pc)) begin
            bad++; $display("FAIL flush_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_wrap;
      id_t         e;
      logic [31:0] waddr[3] = '{32'h20C, 32'hFFFF_FFFC, 32'h0};
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, (k == 0), 32'hFFFF_FFFC, 1'b1);
         total++;
         if (imem_addr !== waddr[k]) begin
            bad++; $display("FAIL wrap_addr%0d got=%h want=%h", k, imem_addr, waddr[k]);
         end
         if (k == 0) exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
         else        exp_q.push_back('{pc: waddr[k], instr: mem_word(waddr[k]), valid: 1'b1});
         tick;
         e = exp_q.pop_front();
         total++;
         if (ID_valid !== e.valid || ID_instr !== e.instr || (e.valid && ID_pc !== e.pc)) begin
            bad++; $display("FAIL wrap_id%0d got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                            k, ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
         end
      end
   endtask

   task automatic test_reset_in_discard;
      id_t e;
      // Redirect while the access to 0x4 is outstanding, then reset mid-discard.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0);
      exp_q.push_back('{pc: 32'h0, instr: NOP, valid: 1'b0});
      tick;
      e = exp_q.pop_front();
      total++;
      if (ID_valid !== e.valid || ID_instr !== e.instr) begin
         bad++; $display("FAIL rstd_redir got instr=%h v=%b want instr=%h v=%b",
                         ID_instr, ID_valid, e.instr, e.valid);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (imem_req !== 1'b0) begin
         bad++; $display("FAIL rstd_req got=%b want=0", imem_req);
      end
      tick;
`ifdef IF_PERF_CNT_EN
      total++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         bad++; $display("FAIL rstd_cnt got stall=%0d flush=%0d want 0 0",
                         perf_stall_cnt, perf_flush_cnt);
      end
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_stall !== 1'b1) begin
         bad++; $display("FAIL rstd_fetch got req=%b addr=%h stall=%b want 1 00000000 1",
                         imem_req, imem_addr, fetch_stall);
      end
      tick;
`ifdef IF_PERF_CNT_EN
      total++;
      if (perf_stall_cnt !== 32'd1) begin
         bad++; $display("FAIL stall_cnt got=%0d want=1", perf_stall_cnt);
      end
`endif
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      exp_q.push_back('{pc: 32'h0, instr: mem_word(32'h0), valid: 1'b1});
      tick;
      e = exp_q.pop_front();
      total++;
      if (ID_valid !== e.valid || ID_instr !== e.instr || ID_pc !== e.pc) begin
         bad++; $display("FAIL rstd_id got pc=%h instr=%h v=%b want pc=%h instr=%h v=%b",
                         ID_pc, ID_instr, ID_valid, e.pc, e.instr, e.valid);
      end
   endtask

   initial begin
      test_reset;
      test_stream;
      test_wait;
      test_freeze;
      test_redirect_discard;
      test_redirect_freeze;
      test_flush;
      test_wrap;
      test_reset_in_discard;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
